// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with memory-response capture and optional
// performance counters (enabled by defining PIPE_CTRL_PERF_EN).
module pipe_ctrl #(
   parameter int NUM_STAGES  = 5,
   parameter int HAZ_STAGE   = 2,
   parameter int FLUSH_STAGE = 3,
   parameter int DATA_W      = 32,
   parameter int CTR_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_req,
   input  logic                  imem_resp,
   input  logic [DATA_W-1:0]     imem_rdata,
   input  logic                  dmem_req,
   input  logic                  dmem_resp,
   input  logic [DATA_W-1:0]     dmem_rdata,
   input  logic                  hazard_stall,
   input  logic                  redirect,
   input  logic                  perf_clr,
   output logic [NUM_STAGES-1:0] stage_load,
   output logic [NUM_STAGES-1:0] stage_flush,
   output logic [DATA_W-1:0]     fetch_rdata,
   output logic [DATA_W-1:0]     mem_rdata,
   output logic [CTR_W-1:0]      cyc_ctr,
   output logic [CTR_W-1:0]      mem_stall_ctr,
   output logic [CTR_W-1:0]      haz_stall_ctr,
   output logic [CTR_W-1:0]      redirect_ctr
);

   generate
      if (!(1 <= HAZ_STAGE && HAZ_STAGE < FLUSH_STAGE && FLUSH_STAGE < NUM_STAGES)) begin : g_bad_params
         $error("pipe_ctrl: requires 1 <= HAZ_STAGE < FLUSH_STAGE < NUM_STAGES");
      end
   endgenerate

   logic              i_done, d_done;
   logic [DATA_W-1:0] i_cap, d_cap;
   logic              mem_stall, advance;

   assign mem_stall = (imem_req & ~(imem_resp | i_done)) |
                      (dmem_req & ~(dmem_resp | d_done));
   assign advance   = ~mem_stall;

   // A response landing while the other channel still stalls is parked here
   // until the whole pipe advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         i_done <= 1'b0;
         d_done <= 1'b0;
         // NOTE: capture registers are reset too, so stale data never leaks after reset.
         i_cap  <= '0;
         d_cap  <= '0;
      end else if (advance) begin
         i_done <= 1'b0;
         d_done <= 1'b0;
      end else begin
         if (imem_req && imem_resp) begin
            i_done <= 1'b1;
            i_cap  <= imem_rdata;
         end
         if (dmem_req && dmem_resp) begin
            d_done <= 1'b1;
            d_cap  <= dmem_rdata;
         end
      end
   end

   assign fetch_rdata = i_done ? i_cap : imem_rdata;
   assign mem_rdata   = d_done ? d_cap : dmem_rdata;

   logic [NUM_STAGES-1:0] haz_load, haz_flush, redir_flush;

   always_comb begin
      // NOTE: defaults first so no path through this block infers a latch.
      haz_load    = '0;
      haz_flush   = '0;
      redir_flush = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         haz_load[i]    = (i >= HAZ_STAGE);
         haz_flush[i]   = (i == HAZ_STAGE);
         redir_flush[i] = (i >= 1) && (i < FLUSH_STAGE);
      end
   end

   // Redirect wins over hazard; both wait while memory stalls.
   always_comb begin
      stage_load  = '0;
      stage_flush = '0;
      if (rst) begin
         stage_flush = '1;
      end else if (advance) begin
         if (redirect) begin
            stage_load  = '1;
            stage_flush = redir_flush;
         end else if (hazard_stall) begin
            stage_load  = haz_load;
            stage_flush = haz_flush;
         end else begin
            stage_load  = '1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

   logic [CTR_W-1:0] cyc_q, mem_q, haz_q, red_q;

   function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c, input logic en);
      return (en && (c != '1)) ? c + CTR_ONE : c;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q <= '0;
         mem_q <= '0;
         haz_q <= '0;
         red_q <= '0;
      end else if (perf_clr) begin
         cyc_q <= '0;
         mem_q <= '0;
         haz_q <= '0;
         red_q <= '0;
      end else begin
         cyc_q <= sat_inc(cyc_q, 1'b1);
         mem_q <= sat_inc(mem_q, mem_stall);
         haz_q <= sat_inc(haz_q, advance & hazard_stall & ~redirect);
         red_q <= sat_inc(red_q, advance & redirect);
      end
   end

   assign cyc_ctr       = cyc_q;
   assign mem_stall_ctr = mem_q;
   assign haz_stall_ctr = haz_q;
   assign redirect_ctr  = red_q;
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;

   assign cyc_ctr       = '0;
   assign mem_stall_ctr = '0;
   assign haz_stall_ctr = '0;
   assign redirect_ctr  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: fixed vectors, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_pipe_ctrl;

   localparam int NS   = 5;
   localparam int HZ   = 2;
   localparam int FL   = 3;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req, imem_resp, dmem_req, dmem_resp;
   logic [31:0]   imem_rdata, dmem_rdata;
   logic          hazard_stall, redirect, perf_clr;
   logic [NS-1:0] stage_load, stage_flush;
   logic [31:0]   fetch_rdata, mem_rdata;
   logic [CW-1:0] cyc_ctr, mem_stall_ctr, haz_stall_ctr, redirect_ctr;

   pipe_ctrl #(.NUM_STAGES(NS), .HAZ_STAGE(HZ), .FLUSH_STAGE(FL), .DATA_W(32), .CTR_W(CW)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .hazard_stall(hazard_stall), .redirect(redirect), .perf_clr(perf_clr),
      .stage_load(stage_load), .stage_flush(stage_flush),
      .fetch_rdata(fetch_rdata), .mem_rdata(mem_rdata),
      .cyc_ctr(cyc_ctr), .mem_stall_ctr(mem_stall_ctr),
      .haz_stall_ctr(haz_stall_ctr), .redirect_ctr(redirect_ctr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ireq, iresp, dreq, dresp, haz, redir, clr;
      logic [31:0] idata, ddata;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [NS-1:0] load, flush;
   } vec_t;

   int checks = 0;
   int failures = 0;

   // Model state: whether each channel's answer is already in hand.
   bit          m_i_got, m_d_got;
   logic [31:0] m_i_buf, m_d_buf;
   int          m_cyc, m_mem, m_haz, m_red;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int c, input bit en);
      return (PERF && en && c < CMAX) ? c + 1 : c;
   endfunction

   task automatic model_reset();
      m_i_got = 0; m_d_got = 0; m_i_buf = '0; m_d_buf = '0;
      m_cyc = 0; m_mem = 0; m_haz = 0; m_red = 0;
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.ireq = 0; s.iresp = 0; s.dreq = 0; s.dresp = 0;
      s.haz = 0; s.redir = 0; s.clr = 0;
      s.idata = 32'h0; s.ddata = 32'h0;
      return s;
   endfunction

   // One clock: check registered counters, drive inputs, check combinational
   // outputs before the rising edge, then advance the model.
   task automatic cycle(input stim_t s, input string tag, output bit adv);
      bit stall;
      int all_ones;
      logic [NS-1:0] e_load, e_flush;
      @(negedge clk);
      check({tag, " cyc_ctr"},       64'(cyc_ctr),       64'(m_cyc));
      check({tag, " mem_stall_ctr"}, 64'(mem_stall_ctr), 64'(m_mem));
      check({tag, " haz_stall_ctr"}, 64'(haz_stall_ctr), 64'(m_haz));
      check({tag, " redirect_ctr"},  64'(redirect_ctr),  64'(m_red));
      imem_req = s.ireq; imem_resp = s.iresp; imem_rdata = s.idata;
      dmem_req = s.dreq; dmem_resp = s.dresp; dmem_rdata = s.ddata;
      hazard_stall = s.haz; redirect = s.redir; perf_clr = s.clr;
      #1;
      stall = (s.ireq && !s.iresp && !m_i_got) || (s.dreq && !s.dresp && !m_d_got);
      all_ones = (1 << NS) - 1;
      if (stall) begin
         e_load = '0; e_flush = '0;
      end else if (s.redir) begin
         e_load = NS'(all_ones); e_flush = NS'(((1 << FL) - 1) - 1);
      end else if (s.haz) begin
         e_load = NS'(all_ones - ((1 << HZ) - 1)); e_flush = NS'(1 << HZ);
      end else begin
         e_load = NS'(all_ones); e_flush = '0;
      end
      check({tag, " stage_load"},  64'(stage_load),  64'(e_load));
      check({tag, " stage_flush"}, 64'(stage_flush), 64'(e_flush));
      check({tag, " fetch_rdata"}, 64'(fetch_rdata), 64'(m_i_got ? m_i_buf : s.idata));
      check({tag, " mem_rdata"},   64'(mem_rdata),   64'(m_d_got ? m_d_buf : s.ddata));
      if (stall) begin
         if (s.ireq && s.iresp) begin m_i_got = 1; m_i_buf = s.idata; end
         if (s.dreq && s.dresp) begin m_d_got = 1; m_d_buf = s.ddata; end
      end else begin
         m_i_got = 0; m_d_got = 0;
      end
      if (s.clr) begin
         m_cyc = 0; m_mem = 0; m_haz = 0; m_red = 0;
      end else begin
         m_cyc = sat(m_cyc, 1'b1);
         m_mem = sat(m_mem, stall);
         m_haz = sat(m_haz, !stall && s.haz && !s.redir);
         m_red = sat(m_red, !stall && s.redir);
      end
      adv = !stall;
   endtask

   initial begin
      vec_t  vecs[7];
      stim_t s;
      bit    adv;
      bit    i_act, d_act;

      // Single-cycle vectors from a clean state (no done flags are left behind).
      for (int i = 0; i < 7; i++) vecs[i].s = idle();
      vecs[0].s.haz = 1;                                           vecs[0].load = 5'b11100; vecs[0].flush = 5'b00100;
      vecs[1].s.haz = 1; vecs[1].s.redir = 1;                      vecs[1].load = 5'b11111; vecs[1].flush = 5'b00110;
      vecs[2].load = 5'b11111;                                                               vecs[2].flush = 5'b00000;
      vecs[3].s.ireq = 1;                                          vecs[3].load = 5'b00000; vecs[3].flush = 5'b00000;
      vecs[4].s.ireq = 1; vecs[4].s.iresp = 1; vecs[4].s.idata = 32'h1111_2222;
                                                                   vecs[4].load = 5'b11111; vecs[4].flush = 5'b00000;
      vecs[5].s.dreq = 1; vecs[5].s.haz = 1;                       vecs[5].load = 5'b00000; vecs[5].flush = 5'b00000;
      vecs[6].s.dreq = 1; vecs[6].s.dresp = 1; vecs[6].s.redir = 1; vecs[6].s.ddata = 32'hCAFE_0001;
                                                                   vecs[6].load = 5'b11111; vecs[6].flush = 5'b00110;

      // Reset state.
      rst = 1'b1;
      imem_req = 0; imem_resp = 0; imem_rdata = 32'h5A5A_0000;
      dmem_req = 0; dmem_resp = 0; dmem_rdata = 32'h0000_A5A5;
      hazard_stall = 1; redirect = 1; perf_clr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("reset stage_load",  64'(stage_load),  64'h0);
      check("reset stage_flush", 64'(stage_flush), 64'h1F);
      check("reset fetch_rdata", 64'(fetch_rdata), 64'h5A5A_0000);
      check("reset mem_rdata",   64'(mem_rdata),   64'h0000_A5A5);
      check("reset haz_ctr",     64'(haz_stall_ctr), 64'h0);
      check("reset cyc_ctr",     64'(cyc_ctr),     64'h0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         cycle(vecs[i].s, $sformatf("vec%0d", i), adv);
         check($sformatf("vec%0d table load", i),  64'(stage_load),  64'(vecs[i].load));
         check($sformatf("vec%0d table flush", i), 64'(stage_flush), 64'(vecs[i].flush));
      end

      // Both requests; imem answers at cycle 2, dmem at cycle 5.
      for (int k = 0; k < 7; k++) begin
         s = idle();
         s.ireq = (k <= 5); s.dreq = (k <= 5);
         s.iresp = (k == 2); s.dresp = (k == 5);
         s.idata = (k == 2) ? 32'h0000_0013 : 32'hDEAD_0000 + 32'(k);
         s.ddata = 32'hAAAA_5555;
         cycle(s, $sformatf("seq_both c%0d", k), adv);
         if (k <= 4) check($sformatf("seq_both load0 c%0d", k), 64'(stage_load), 64'h0);
         if (k >= 2 && k <= 5) check($sformatf("seq_both fetch c%0d", k), 64'(fetch_rdata), 64'h13);
         if (k == 5) check("seq_both load1 c5", 64'(stage_load), 64'h1F);
         if (k == 6) begin
            check("seq_both i_done c6", 64'(dut.i_done), 64'h0);
            check("seq_both fetch c6", 64'(fetch_rdata), 64'hDEAD_0006);
         end
      end

      // Redirect held across a 3-cycle dmem stall.
      for (int k = 0; k < 4; k++) begin
         s = idle();
         s.dreq = 1; s.redir = 1; s.dresp = (k == 3); s.ddata = 32'h0BAD_F00D;
         cycle(s, $sformatf("seq_redir c%0d", k), adv);
         check($sformatf("seq_redir flush c%0d", k), 64'(stage_flush), (k == 3) ? 64'h06 : 64'h00);
      end

      // Async reset while imem response is parked behind a dmem stall.
      s = idle();
      s.ireq = 1; s.dreq = 1; s.iresp = 1; s.idata = 32'h0000_0077;
      cycle(s, "seq_arst c0", adv);
      @(posedge clk);
      #1;
      imem_resp = 0; imem_rdata = 32'h0000_0099;
      #1;
      check("seq_arst i_done set", 64'(dut.i_done), 64'h1);
      check("seq_arst held fetch", 64'(fetch_rdata), 64'h77);
      rst = 1'b1;
      #1;
      check("seq_arst i_done", 64'(dut.i_done), 64'h0);
      check("seq_arst flush", 64'(stage_flush), 64'h1F);
      check("seq_arst load", 64'(stage_load), 64'h0);
      check("seq_arst fetch", 64'(fetch_rdata), 64'h99);
      model_reset();
      @(negedge clk);
      imem_req = 0; dmem_req = 0;
      rst = 1'b0;

      // Counter saturation and clear priority.
      s = idle();
      s.haz = 1;
      for (int k = 0; k < 20; k++) cycle(s, $sformatf("seq_sat c%0d", k), adv);
      s = idle();
      s.clr = 1; s.haz = 1;
      cycle(s, "seq_sat clr", adv);
      check("seq_sat haz_ctr saturated", 64'(haz_stall_ctr), PERF ? 64'd15 : 64'd0);
      cycle(idle(), "seq_sat after clr", adv);
      check("seq_sat haz_ctr cleared", 64'(haz_stall_ctr), 64'd0);

      // Randomized protocol-following traffic.
      i_act = 0; d_act = 0;
      for (int k = 0; k < 400; k++) begin
         s = idle();
         if (!i_act) i_act = ($urandom_range(1) == 1);
         if (!d_act) d_act = ($urandom_range(2) == 0);
         s.ireq  = i_act;
         s.dreq  = d_act;
         s.iresp = i_act ? (!m_i_got && $urandom_range(2) == 0) : ($urandom_range(7) == 0);
         s.dresp = d_act ? (!m_d_got && $urandom_range(2) == 0) : ($urandom_range(7) == 0);
         s.idata = $urandom;
         s.ddata = $urandom;
         s.haz   = ($urandom_range(3) == 0);
         s.redir = ($urandom_range(4) == 0);
         s.clr   = ($urandom_range(15) == 0);
         cycle(s, $sformatf("rand c%0d", k), adv);
         if (adv) begin i_act = 0; d_act = 0; end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
